pipe_csa_adder: RTL



---
 rtl/pipe_csa_adder_pkg.sv | 27 ++
 rtl/pipe_csa_adder_if.sv | 36 +++
 rtl/pipe_csa_adder_csa_block.sv | 38 +++
 rtl/pipe_csa_adder.sv | 117 +++++++++++
 4 files changed

// File: rtl/pipe_csa_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_csa_pkg                                                 |
// | Description : Shared constants and helpers for the pipelined carry-select  |
// |               adder (default geometry, block-count derivation).            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pipe_csa_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLK   = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int calc_nblk(input int width, input int blk);
    return width / blk;
  endfunction

  function automatic bit params_legal(input int width, input int blk);
    return (blk >= 1) && (width >= blk) && ((width % blk) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_csa_adder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_csa_adder_if                                            |
// | Description : Operand/result handshake bundle for pipe_csa_adder.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface pipe_csa_adder_if
  import pipe_csa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );

endinterface
`default_nettype wire

// File: rtl/pipe_csa_adder_csa_block.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : csa_block                                                    |
// | Description : BLK-bit carry-select slice: both candidate sums, selected by |
// |               the incoming carry; also reports carry into the slice MSB.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module csa_block
  import pipe_csa_pkg::*;
#(
  parameter int BLK = DEF_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout,
  output logic           c_msb
);

  logic [BLK:0] w_sum0;
  logic [BLK:0] w_sum1;
  logic         w_msb0;
  logic         w_msb1;

  assign w_sum0 = {1'b0, a} + {1'b0, b};
  assign w_sum1 = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};

  // Carry into the top bit falls out of the sum bit: s = a ^ b ^ c.
  assign w_msb0 = w_sum0[BLK-1] ^ a[BLK-1] ^ b[BLK-1];
  assign w_msb1 = w_sum1[BLK-1] ^ a[BLK-1] ^ b[BLK-1];

  assign sum   = cin ? w_sum1[BLK-1:0] : w_sum0[BLK-1:0];
  assign cout  = cin ? w_sum1[BLK]     : w_sum0[BLK];
  assign c_msb = cin ? w_msb1          : w_msb0;

endmodule
`default_nettype wire

// File: rtl/pipe_csa_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_csa_adder                                               |
// | Description : NBLK-stage pipelined carry-select adder/subtractor; stage k  |
// |               resolves block k with the carry registered by stage k-1.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_csa_adder
  import pipe_csa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLK   = DEF_BLK
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_csa_adder_if.slave   bus
);

  localparam int NBLK = calc_nblk(WIDTH, BLK);

  if (!params_legal(WIDTH, BLK)) begin : g_param_check
    $fatal(1, "pipe_csa_adder: WIDTH must be a nonzero multiple of BLK");
  end

  logic                        w_adv;
  op_e                         w_op;

  // Per-stage inputs: what each stage's block consumes this cycle.
  logic [NBLK-1:0][WIDTH-1:0]  w_src_a;
  logic [NBLK-1:0][WIDTH-1:0]  w_src_b;
  logic [NBLK-1:0][WIDTH-1:0]  w_src_sum;
  logic [NBLK-1:0][WIDTH-1:0]  w_nxt_sum;
  logic [NBLK-1:0]             w_src_c;
  logic [NBLK-1:0]             w_src_sub;
  logic [NBLK-1:0]             w_src_vld;
  logic [NBLK-1:0][BLK-1:0]    w_blk_sum;
  logic [NBLK-1:0]             w_blk_cout;
  logic [NBLK-1:0]             w_blk_cmsb;

  logic [NBLK-1:0][WIDTH-1:0]  r_a;
  logic [NBLK-1:0][WIDTH-1:0]  r_b;
  logic [NBLK-1:0][WIDTH-1:0]  r_sum;
  logic [NBLK-1:0]             r_vld;
  logic [NBLK-1:0]             r_carry;
  logic [NBLK-1:0]             r_sub;
  logic                        r_ovf;

  logic                        w_unused;

  assign w_op  = op_e'(bus.sub);
  assign w_adv = !r_vld[NBLK-1] | bus.out_ready;

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld[NBLK-1];
  assign bus.s         = r_sum[NBLK-1];
  assign bus.c_out     = r_carry[NBLK-1];
  assign bus.ovf       = r_ovf;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Subtraction is folded in at entry: B is inverted and the carry forced to 1.
      assign w_src_a[k]   = bus.a;
      assign w_src_b[k]   = (w_op == OP_SUB) ? ~bus.b : bus.b;
      assign w_src_c[k]   = (w_op == OP_SUB) | bus.c_in;
      assign w_src_sub[k] = (w_op == OP_SUB);
      assign w_src_vld[k] = bus.in_valid;
      assign w_src_sum[k] = '0;
    end else begin : g_body
      assign w_src_a[k]   = r_a[k-1];
      assign w_src_b[k]   = r_b[k-1];
      assign w_src_c[k]   = r_carry[k-1];
      assign w_src_sub[k] = r_sub[k-1];
      assign w_src_vld[k] = r_vld[k-1];
      assign w_src_sum[k] = r_sum[k-1];
    end

    csa_block #(
      .BLK   (BLK)
    ) u_csa_block (
      .a     (w_src_a[k][k*BLK +: BLK]),
      .b     (w_src_b[k][k*BLK +: BLK]),
      .cin   (w_src_c[k]),
      .sum   (w_blk_sum[k]),
      .cout  (w_blk_cout[k]),
      .c_msb (w_blk_cmsb[k])
    );

    assign w_nxt_sum[k] = w_src_sum[k] | (WIDTH'(w_blk_sum[k]) << (k * BLK));
  end

  // One global enable keeps every stage in lockstep, so a stall freezes the beat order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= '0;
      r_sub   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_adv) begin
      r_vld   <= w_src_vld;
      r_a     <= w_src_a;
      r_b     <= w_src_b;
      r_sum   <= w_nxt_sum;
      r_carry <= w_blk_cout;
      r_sub   <= w_src_sub;
      r_ovf   <= w_blk_cmsb[NBLK-1] ^ w_blk_cout[NBLK-1];
    end
  end

  // Operand bits of already-resolved blocks and the final-stage operands have no reader.
  assign w_unused = &{1'b0, w_src_a, w_src_b, r_a[NBLK-1], r_b[NBLK-1],
                      r_sub[NBLK-1], w_blk_cmsb};

endmodule
`default_nettype wire
